// File: rtl/ram_be_clr.sv
// Word-addressed data memory with per-byte write enables and a sequential clear engine.
// Define RAM_BE_CLR_READ_REG_EN for a registered (read-first, 1-cycle) read port.
module ram_be_clr #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic [DATA_W-1:0]   Data_In,
  input  logic                EN,
  input  logic [DATA_W/8-1:0] Byte_En,
  input  logic                Clr,
  output logic [DATA_W-1:0]   Data_Out,
  output logic                Busy,
  output logic                Dbg_State,
  output logic [ADDR_W-1:0]   Dbg_Cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W / 8;

  // Handshake: none. Writes commit on the rising edge where EN=1 and Busy=0;
  // Clr is sampled on IDLE edges only, and Busy rises right after that edge.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                w_last;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  assign w_last = (r_cnt == {ADDR_W{1'b1}});

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (Clr) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Storage has no reset so it maps onto block RAM; the clear engine initialises it.
  always_ff @(posedge CLK) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= INIT_VAL;
    end else if (EN) begin
      for (int i = 0; i < NB; i++) begin
        if (Byte_En[i]) r_mem[Addr][8*i +: 8] <= Data_In[8*i +: 8];
      end
    end
  end

  assign Busy      = (r_state == ST_CLEAR);
  assign Dbg_State = r_state;
  assign Dbg_Cnt   = r_cnt;

`ifdef RAM_BE_CLR_READ_REG_EN
  logic [DATA_W-1:0] r_dout;

  // Read-first: the register captures the array contents from before this edge's write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dout <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_dout <= '0;
    end else begin
      r_dout <= r_mem[Addr];
    end
  end

  assign Data_Out = r_dout;
`else
  assign Data_Out = Busy ? '0 : r_mem[Addr];
`endif

endmodule

// File: tb/tb_ram_be_clr.sv
// Self-checking bench for ram_be_clr (ADDR_W=4, INIT_VAL=DEADBEEF) with a word-array reference model.
module tb_ram_be_clr;
  localparam int          ADDR_W = 4;
  localparam int          DATA_W = 32;
  localparam int          NB     = DATA_W / 8;
  localparam int          DEPTH  = 2**ADDR_W;
  localparam logic [31:0] INIT   = 32'hDEADBEEF;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              en;
  logic [NB-1:0]     byte_en;
  logic              clr;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              dbg_state;
  logic [ADDR_W-1:0] dbg_cnt;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] model_mem [DEPTH];

  ram_be_clr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_VAL(INIT)) dut (
    .CLK(clk), .RST_N(rst_n), .Addr(addr), .Data_In(data_in), .EN(en),
    .Byte_En(byte_en), .Clr(clr), .Data_Out(data_out), .Busy(busy),
    .Dbg_State(dbg_state), .Dbg_Cnt(dbg_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_write(input int a, input logic [31:0] d, input logic [NB-1:0] be);
    for (int i = 0; i < NB; i++)
      if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input int a, input logic [31:0] d, input logic [NB-1:0] be,
                          input logic we, input logic c);
    addr = ADDR_W'(a); data_in = d; byte_en = be; en = we; clr = c;
    @(posedge clk); #1;
    en = 1'b0; clr = 1'b0;
    if (we) model_write(a, d, be);
    if (c) model_clear();
  endtask

  task automatic do_read(input int a, input string tag);
    en = 1'b0; clr = 1'b0;
`ifdef RAM_BE_CLR_READ_REG_EN
    addr = ADDR_W'(a);
    @(posedge clk); #1;
`else
    @(negedge clk);
    addr = ADDR_W'(a);
    #1;
`endif
    check(tag, data_out, model_mem[a]);
  endtask

  // Counts rising edges until Busy drops (bounded); Data_Out must read 0 while Busy.
  task automatic wait_clear(output int n);
    n = 0;
    for (int k = 0; k < 4*DEPTH; k++) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
      if (data_out !== '0) check("dout_zero_busy", data_out, 32'h0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int a;
    logic [31:0] d;
    logic [NB-1:0] be;

    rst_n = 1'b0; addr = '0; data_in = '0; en = 1'b0; byte_en = '0; clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'hx;
    #22;
    check("reset_busy", {31'b0, busy}, 32'h1);
    check("reset_dout", data_out, 32'h0);
    check("reset_cnt", {28'b0, dbg_cnt}, 32'h0);

    // Reset release at #1 after a posedge, then the full clear.
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    wait_clear(n);
    check("reset_clear_edges", n, DEPTH);
    check("idle_after_clear", {31'b0, busy}, 32'h0);
    for (int i = 0; i < DEPTH; i++) do_read(i, "init_val_read");

    // Byte lanes.
    do_write(5, 32'h11223344, 4'b1111, 1'b1, 1'b0);
    do_write(5, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0);
    do_read(5, "byte_lane_model");
    check("byte_lane_const", model_mem[5], 32'h11BB33DD);

    // Randomized writes (including Byte_En=0 and EN=0 steps) with random readback.
    for (int k = 0; k < 40; k++) begin
      a  = $urandom_range(0, DEPTH-1);
      d  = $urandom;
      be = NB'($urandom_range(0, 15));
      do_write(a, d, be, 1'($urandom_range(0, 3) != 0), 1'b0);
      do_read($urandom_range(0, DEPTH-1), "rand_read");
    end
    for (int i = 0; i < DEPTH; i++) do_read(i, "rand_sweep");

    // Same edge EN+Clr, then write attempts held through the whole clear.
    do_write(3, 32'h0BADF00D, 4'b1111, 1'b1, 1'b0);
    do_write(7, 32'h12345678, 4'b1111, 1'b1, 1'b1);
    check("clr_busy_rise", {31'b0, busy}, 32'h1);
    addr = 4'd3; data_in = 32'hFFFFFFFF; byte_en = 4'hF; en = 1'b1; clr = 1'b1;
    n = 0;
    for (int k = 0; k < 4*DEPTH; k++) begin
      @(posedge clk); #1;
      n++;
      if (!busy) break;
      if (data_out !== '0) check("dout_zero_busy", data_out, 32'h0);
    end
    en = 1'b0; clr = 1'b0;
    check("clr_edges", n, DEPTH - 1 + 1 - 1 + 1);
    do_read(7, "clr_overrides_write");
    do_read(3, "write_ignored_in_clear");
    check("addr3_init", model_mem[3], INIT);

    // Reset mid-clear at Cnt=9 restarts from 0 and lasts a full DEPTH edges.
    do_write(0, 32'h0, 4'h0, 1'b0, 1'b1);
    n = 0;
    while (dbg_cnt != 4'd9 && n < 4*DEPTH) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_cnt9", {28'b0, dbg_cnt}, 32'd9);
    rst_n = 1'b0;
    #3;
    check("midreset_cnt", {28'b0, dbg_cnt}, 32'h0);
    check("midreset_busy", {31'b0, busy}, 32'h1);
    rst_n = 1'b1;
    wait_clear(n);
    check("midreset_clear_edges", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) do_read(i, "midreset_sweep");

    // Read-during-write to the same address.
    do_write(2, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b0);
`ifdef RAM_BE_CLR_READ_REG_EN
    addr = 4'd2; data_in = 32'hCAFEF00D; byte_en = 4'hF; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    check("rdw_old", data_out, 32'h5A5A5A5A);
    @(posedge clk); #1;
    check("rdw_new", data_out, 32'hCAFEF00D);
`else
    @(negedge clk);
    addr = 4'd2; data_in = 32'hCAFEF00D; byte_en = 4'hF; en = 1'b1;
    #1;
    check("rdw_old", data_out, 32'h5A5A5A5A);
    @(posedge clk); #1;
    en = 1'b0;
    check("rdw_new", data_out, 32'hCAFEF00D);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_be_clr.md
# ram_be_clr

Parametrised word-addressed data memory for the ARMv4 datapath, replacing the fixed 1024×32 RAM. It adds per-byte write enables, a configurable width and depth, and a sequential clear engine. The clear engine initialises every word over DEPTH cycles after reset, or on request, instead of clearing the whole array in one edge. The block sits on the core's data-memory port, behind the ALU address path.

## Interface
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W
- DATA_W, 32, word width; must be a multiple of 8; NB = DATA_W/8 byte lanes
- INIT_VAL, 0, DATA_W-bit value written to every word by the clear engine
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- Addr  in  ADDR_W  word address for read and write
- Data_In  in  DATA_W  write data
- EN  in  1  write enable
- Byte_En  in  NB  lane mask; bit i qualifies Data_In[8i+7:8i]
- Clr  in  1  clear request, single-cycle pulse or level
- Data_Out  out  DATA_W  read data
- Busy  out  1  high while the clear engine runs

## Operation
- FSM has two states: CLEAR and IDLE, plus a clear counter Cnt[ADDR_W-1:0].
- Reset (RST_N low):
  - state=CLEAR, Cnt=0, Busy=1, Data_Out=0.
  - Array contents are not touched asynchronously; no reset on storage, so it infers block RAM.
- In CLEAR, each rising edge:
  - Memory[Cnt] <= INIT_VAL.
  - At Cnt=DEPTH-1 go to IDLE; otherwise Cnt++.
- CLEAR ignores user inputs:
  - EN and Byte_En are ignored.
  - Clr is ignored; it does not restart the clear.
  - Data_Out is forced to 0.
- In IDLE with EN=1:
  - Each lane i where Byte_En[i]=1 writes Memory[Addr][8i+7:8i] <= Data_In[8i+7:8i].
  - Other lanes keep their value.
  - EN=1 with Byte_En=0 is a no-op.
- In IDLE with Clr=1 at an edge: go to CLEAR with Cnt=0.
- Clr and EN both high in the same IDLE edge:
  - The write is performed at that edge.
  - The new clear then overwrites it.
- Read (IDLE): Data_Out = Memory[Addr], as set by the configuration macro.
- Reset asserted mid-clear restarts the clear from address 0. Words already cleared stay at INIT_VAL.
- Addr never goes out of range: full ADDR_W decode, no wrap logic needed.

## Timing
- Clear duration: Busy is high for exactly DEPTH rising edges after RST_N release, or after the edge that sampled Clr.
  - Busy falls right after the edge that writes address DEPTH-1.
- Clr latency: Busy goes high right after the edge sampling Clr in IDLE.
- Write latency: the write commits at the rising edge where EN=1.
- Combinational read:
  - Data_Out reflects a new write immediately after that edge.
  - Same-cycle read of a written Addr returns old data before the edge and new data after it.
- Registered read: see Configuration.
- First user write is accepted on the first edge where Busy=0 at sampling.

## Configuration
- Macro: RAM_BE_CLR_READ_REG_EN.
- Defined:
  - Data_Out is a register loaded at each rising edge with Memory[Addr], giving 1-cycle read latency.
  - Read-during-write to the same Addr returns old data (read-first).
  - The register resets to 0 and loads 0 while in CLEAR.
- Undefined: Data_Out is combinational with 0-cycle read latency, muxed to 0 while Busy.

## Test plan
- Reset clear, ADDR_W=4:
  - Release RST_N, count edges -> Busy high for exactly 16 edges, then low.
  - Every word reads INIT_VAL. With INIT_VAL=32'hDEADBEEF, all 16 reads return DEADBEEF.
- Byte lanes:
  - Write 32'h11223344 to Addr 5 with Byte_En=4'b1111, then 32'hAABBCCDD with Byte_En=4'b0101 -> reads 32'h11BB33DD.
- Writes during clear:
  - Assert EN with Data_In=32'hFFFFFFFF to Addr 3 throughout Busy -> after Busy falls, Addr 3 reads INIT_VAL.
  - Data_Out is 0 while Busy.
- Clr with write:
  - Same edge, EN=1 (Addr 7, 32'h12345678) and Clr=1 -> Busy rises next cycle.
  - After DEPTH edges, Addr 7 reads INIT_VAL.
- Reset mid-clear:
  - Pulse RST_N low at Cnt=9 -> Cnt restarts at 0 and Busy lasts a full DEPTH edges again.
- Macro-defined build:
  - Write 32'hCAFEF00D to Addr 2 while reading Addr 2 -> Data_Out shows old value after that edge.
  - CAFEF00D appears one edge later.
